// File: rtl/pc_fetch_unit_pkg.sv
// Shared encodings for the fetch sequencer. Decode and branch units import the
// same state codes and PC defaults from here.
package pc_fetch_unit_pkg;

    localparam int DEFAULT_PC_WIDTH  = 32;
    localparam int DEFAULT_RESET_PC  = 0;
    localparam int DEFAULT_MEM_DEPTH = 128;

    localparam logic [1:0] ST_BOOT   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    typedef enum logic [1:0] {
        BOOT   = ST_BOOT,
        RUN    = ST_RUN,
        HALTED = ST_HALTED
    } state_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Control and fetch-tag bundle between the PC sequencer and the pipeline front end.
// The master side is the sequencer; the slave side supplies stall/redirect/halt.
interface pc_fetch_unit_if
    import pc_fetch_unit_pkg::*;
#(
    parameter int PC_WIDTH = DEFAULT_PC_WIDTH
);
    logic                stall;
    logic                redirect_valid;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic                halt;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] fetch_pc;
    logic                fetch_valid;
    logic                halted;

    modport master (
        input  stall, redirect_valid, redirect_pc, halt,
        output pc, fetch_pc, fetch_valid, halted
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, halt,
        input  pc, fetch_pc, fetch_valid, halted
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program-counter sequencer for a one-cycle registered instruction memory.
// Tags the word on the memory output with fetch_pc/fetch_valid; handles stall, redirect, wrap, halt.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int PC_WIDTH  = DEFAULT_PC_WIDTH,
    parameter int RESET_PC  = DEFAULT_RESET_PC,
    parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    pc_fetch_unit_if.master        bus
);

    localparam logic [PC_WIDTH-1:0] PC_MASK  = PC_WIDTH'(MEM_DEPTH - 1);
    localparam logic [PC_WIDTH-1:0] BOOT_PC  = PC_WIDTH'(RESET_PC) & PC_MASK;
    localparam logic [PC_WIDTH-1:0] FIRST_PC = PC_WIDTH'(RESET_PC + 1) & PC_MASK;

    state_t              state;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] fetch_pc;
    logic                fetch_valid;
    logic                halted;

    // All PC values live inside the memory; upper bits are forced to zero.
    function automatic logic [PC_WIDTH-1:0] wrap(input logic [PC_WIDTH-1:0] v);
        return v & PC_MASK;
    endfunction

    // NOTE: every state register below is assigned with <= so all updates see
    // the pre-edge values; blocking assignments here would chain pc into fetch_pc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= BOOT_PC;
            fetch_pc    <= '0;
            fetch_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state       <= RUN;
                    pc          <= FIRST_PC;
                    fetch_pc    <= BOOT_PC;
                    fetch_valid <= 1'b1;
                end
                RUN: begin
                    if (bus.halt) begin
                        state       <= HALTED;
                        halted      <= 1'b1;
                        fetch_valid <= 1'b0;
                    end else if (bus.redirect_valid) begin
                        // The word read this cycle is wrong-path; squash it.
                        pc          <= wrap(bus.redirect_pc);
                        fetch_valid <= 1'b0;
                    end else if (!bus.stall) begin
                        fetch_pc    <= pc;
                        fetch_valid <= 1'b1;
                        pc          <= wrap(pc + PC_WIDTH'(1));
                    end
                end
                HALTED: begin
                    fetch_valid <= 1'b0;
                    halted      <= 1'b1;
                end
                default: begin
                    state       <= BOOT;
                    pc          <= BOOT_PC;
                    fetch_pc    <= '0;
                    fetch_valid <= 1'b0;
                    halted      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc          = pc;
    assign bus.fetch_pc    = fetch_pc;
    assign bus.fetch_valid = fetch_valid;
    assign bus.halted      = halted;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed scoreboard bench for pc_fetch_unit: expected outputs are queued as
// each step is driven and compared one cycle later, plus async reset checks.
module tb_pc_fetch_unit;
    import pc_fetch_unit_pkg::*;

    localparam int PC_WIDTH = 32;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] fetch_pc;
        logic        fetch_valid;
        logic        halted;
        logic        chk_fpc;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb[$];

    pc_fetch_unit_if #(.PC_WIDTH(PC_WIDTH)) bus ();

    pc_fetch_unit #(.PC_WIDTH(PC_WIDTH), .RESET_PC(0), .MEM_DEPTH(128)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic compare_head();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard: observed empty queue expected entry");
            return;
        end
        e = sb.pop_front();
        check_val({e.tag, ".pc"}, bus.pc, e.pc);
        check_val({e.tag, ".fetch_valid"}, 32'(bus.fetch_valid), 32'(e.fetch_valid));
        check_val({e.tag, ".halted"}, 32'(bus.halted), 32'(e.halted));
        if (e.chk_fpc)
            check_val({e.tag, ".fetch_pc"}, bus.fetch_pc, e.fetch_pc);
    endtask

    task automatic push_exp(input string tag, input logic [31:0] epc, input logic [31:0] efpc,
                            input logic efv, input logic eh, input logic chk);
        exp_t e;
        e.tag = tag; e.pc = epc; e.fetch_pc = efpc;
        e.fetch_valid = efv; e.halted = eh; e.chk_fpc = chk;
        sb.push_back(e);
    endtask

    // Drive inputs, queue the expectation for the next edge, then compare after it.
    task automatic step(input string tag, input logic s, input logic r, input logic [31:0] rp,
                        input logic h, input logic [31:0] epc, input logic [31:0] efpc,
                        input logic efv, input logic eh, input logic chk);
        bus.stall = s; bus.redirect_valid = r; bus.redirect_pc = rp; bus.halt = h;
        push_exp(tag, epc, efpc, efv, eh, chk);
        @(posedge clk);
        #1;
        compare_head();
    endtask

    task automatic idle();
        bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.halt = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        idle();
        #12;
        push_exp("reset", 0, 0, 1'b0, 1'b0, 1'b1);
        compare_head();
        rst = 1'b0;
        #1;
        push_exp("boot", 0, 0, 1'b0, 1'b0, 1'b1);
        compare_head();

        step("run0", 0, 0, 0, 0,  1, 0, 1, 0, 1);
        step("run1", 0, 0, 0, 0,  2, 1, 1, 0, 1);
        step("run2", 0, 0, 0, 0,  3, 2, 1, 0, 1);
        step("run3", 0, 0, 0, 0,  4, 3, 1, 0, 1);
        step("run4", 0, 0, 0, 0,  5, 4, 1, 0, 1);
        step("run5", 0, 0, 0, 0,  6, 5, 1, 0, 1);
        for (int i = 0; i < 3; i++)
            step("stall", 1, 0, 0, 0,  6, 5, 1, 0, 1);
        step("unstall", 0, 0, 0, 0,  7, 6, 1, 0, 1);
        step("run7", 0, 0, 0, 0,  8, 7, 1, 0, 1);
        step("run8", 0, 0, 0, 0,  9, 8, 1, 0, 1);
        step("run9", 0, 0, 0, 0, 10, 9, 1, 0, 1);

        step("redir40", 0, 1, 40, 0,  40, 0, 0, 0, 0);
        step("tgt40", 0, 0, 0, 0,     41, 40, 1, 0, 1);
        step("redir200", 0, 1, 200, 0, 72, 0, 0, 0, 0);
        step("tgt72", 0, 0, 0, 0,     73, 72, 1, 0, 1);
        step("redir_stall", 1, 1, 100, 0, 100, 0, 0, 0, 0);
        step("squash_stall", 1, 0, 0, 0, 100, 0, 0, 0, 0);
        step("tgt100", 0, 0, 0, 0,    101, 100, 1, 0, 1);

        step("redir126", 0, 1, 126, 0, 126, 0, 0, 0, 0);
        step("wrap126", 0, 0, 0, 0,   127, 126, 1, 0, 1);
        step("wrap127", 0, 0, 0, 0,     0, 127, 1, 0, 1);
        step("wrap0", 0, 0, 0, 0,       1, 0, 1, 0, 1);
        step("wrap1", 0, 0, 0, 0,       2, 1, 1, 0, 1);

        // Asynchronous reset in the middle of a RUN cycle, well before the next edge.
        #2;
        rst = 1'b1;
        #1;
        push_exp("async_rst", 0, 0, 1'b0, 1'b0, 1'b1);
        compare_head();
        #1;
        rst = 1'b0;
        #1;
        push_exp("reboot", 0, 0, 1'b0, 1'b0, 1'b1);
        compare_head();
        step("rerun0", 0, 0, 0, 0, 1, 0, 1, 0, 1);
        step("rerun1", 0, 0, 0, 0, 2, 1, 1, 0, 1);
        step("rerun2", 0, 0, 0, 0, 3, 2, 1, 0, 1);

        step("halt_redir", 0, 1, 50, 1, 3, 2, 0, 1, 1);
        step("halted_redir", 0, 1, 9, 0, 3, 2, 0, 1, 1);
        step("halted_stall", 1, 0, 0, 0, 3, 2, 0, 1, 1);
        step("halted_idle", 0, 0, 0, 0, 3, 2, 0, 1, 1);

        #2;
        rst = 1'b1;
        #1;
        push_exp("halt_exit", 0, 0, 1'b0, 1'b0, 1'b1);
        compare_head();
        rst = 1'b0;
        idle();
        step("post_halt", 0, 0, 0, 0, 1, 0, 1, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter sequencer sitting directly upstream of the instruction memory. It drives the word-indexed `pc` into the memory and tracks which fetched instruction is valid, given the memory's one-cycle registered read. It also handles stall, branch redirect with wrong-path squash, wrap-around and halt. Downstream decode consumes `inst` from the memory qualified by `fetch_valid` / `fetch_pc` from this block.

## Interface
- `PC_WIDTH`, 32, width of all PC values.
- `RESET_PC`, 0, word index fetched first after reset.
- `MEM_DEPTH`, 128, instruction memory depth in words; power of two.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  downstream cannot accept; hold fetch stream.
- `redirect_valid`  in  1  taken branch/jump; load `redirect_pc`.
- `redirect_pc`  in  PC_WIDTH  redirect target, word index.
- `halt`  in  1  stop fetching until reset.
- `pc`  out  PC_WIDTH  word address presented to instruction memory.
- `fetch_pc`  out  PC_WIDTH  PC of the instruction currently on memory `inst`.
- `fetch_valid`  out  1  memory `inst` is a valid, non-squashed instruction.
- `halted`  out  1  block is in HALTED.

## Operation
- States: BOOT, RUN, HALTED. The state encoding is a localparam.
- Reset (async) forces the following: state=BOOT, `pc`=RESET_PC, `fetch_pc`=0, `fetch_valid`=0, `halted`=0.
- BOOT: one cycle.
  - `pc` holds RESET_PC so the memory reads it.
  - Transitions to RUN next edge with `pc`=RESET_PC+1, `fetch_pc`=RESET_PC, `fetch_valid`=1.
- RUN, priority halt > redirect > stall > increment:
  - halt: go to HALTED. `pc` holds. `fetch_valid`=0 from next cycle.
  - redirect: `pc`←`redirect_pc` mod MEM_DEPTH. Next cycle `fetch_valid`=0, squashing the wrong-path word being read.
  - stall: `pc`, `fetch_pc`, `fetch_valid` all hold. The memory re-reads the same word, so `inst` is stable.
  - otherwise: `fetch_pc`←`pc`, `fetch_valid`←1, `pc`←(`pc`+1) mod MEM_DEPTH.
- After a squash cycle, the next non-stalled edge resumes normally: `fetch_pc`=redirect target, `fetch_valid`=1.
- Redirect while stalled: the redirect wins. Stall is ignored that cycle.
- HALTED: all outputs hold, `fetch_valid`=0, `halted`=1. All inputs are ignored. Only `rst` exits.
- All PC arithmetic is modulo MEM_DEPTH; bits above log2(MEM_DEPTH) are always 0 on `pc` and `fetch_pc`.

## Timing
- Fetch latency: an instruction at `pc` presented in cycle t appears on `inst` in cycle t+1. `fetch_pc`/`fetch_valid` are aligned with it in t+1.
- Redirect penalty: 1 bubble cycle. The target instruction is valid 2 cycles after `redirect_valid` is sampled.
- Throughput: 1 instruction/cycle when not stalled.
- Halt takes effect at the sampling edge. The instruction already on `inst` at that edge is the last with `fetch_valid`=1.
- Wrap-around: `pc`=MEM_DEPTH-1 increments to 0 with no bubble.
- Reset mid-operation: outputs return to reset values immediately (asynchronously), not at the next edge.
- All outputs are registered; no combinational input→output paths.

## Structure
- Shared package holds:
  - the PC width constant;
  - the state typedef/constants (BOOT, RUN, HALTED);
  - RESET_PC default,

  so that decode and branch units use the same encodings.
- Single module, no sub-modules. The next-PC mux and increment are inline. A separate `next_pc_sel` sub-module is not warranted.

## Test plan
- Reset release, no other inputs → `pc` sequence 0,1,2,3…; `fetch_valid` rises on cycle 2 with `fetch_pc`=0, then `fetch_pc` increments by 1 per cycle.
- `stall` held 3 cycles at `fetch_pc`=5 → `pc`=6 and `fetch_pc`=5 held 3 cycles, `fetch_valid`=1; resumes with `fetch_pc`=6.
- `redirect_valid`=1, `redirect_pc`=40 while `pc`=10 → next cycle `pc`=40, `fetch_valid`=0; the following cycle `fetch_pc`=40, `fetch_valid`=1. Repeat with `redirect_pc`=200 → target 72. Repeat with stall asserted simultaneously → redirect still taken.
- Free-run from `pc`=126 → `pc` 127, 0, 1 with `fetch_valid` continuously 1 and `fetch_pc` 126, 127, 0.
- `halt` and `redirect_valid` asserted together → `halted`=1, `fetch_valid`=0 from next cycle, `pc` frozen; further stimulus is ignored.
- `rst` asserted mid-cycle during RUN → outputs go to reset values before the next edge; the reset sequence then matches the first scenario.
